// File: rtl/farm_sensor_conditioner.sv
// Farm-road detector conditioner: synchronise, debounce and shape the
// loop-detector level into the S request for the light controller.
module farm_sensor_conditioner #(
    parameter int unsigned DEB_TICKS  = 4,
    parameter int unsigned MIN_TICKS  = 8,
    parameter int unsigned EXT_TICKS  = 3,
    parameter int unsigned MAX_TICKS  = 60,
    parameter int unsigned COOL_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       det_raw,
    input  logic       clr_count,
    output logic       s_req,
    output logic       det_clean,
    output logic [7:0] veh_count,
    output logic       cooldown
);

    typedef enum logic [1:0] {IDLE, REQ, EXT, COOL} state_e;

    localparam logic [7:0] DEB_L  = DEB_TICKS[7:0];
    localparam logic [7:0] MIN_L  = MIN_TICKS[7:0];
    localparam logic [7:0] EXT_L  = EXT_TICKS[7:0];
    localparam logic [7:0] MAX_L  = MAX_TICKS[7:0];
    localparam logic [7:0] COOL_L = COOL_TICKS[7:0];

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       det_clean_q, det_clean_d;
    logic       clean_prev_q, clean_prev_d;
    logic [7:0] deb_q, deb_d;
    logic [7:0] veh_q, veh_d;
    state_e     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] max_q, max_d;
    logic [7:0] ext_q, ext_d;
    logic [7:0] cool_q, cool_d;
    logic       s_req_q, s_req_d;
    logic       cooldown_q, cooldown_d;
    logic       rise;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        sync1_d      = det_raw;
        sync2_d      = sync1_q;
        clean_prev_d = det_clean_q;
        deb_d        = deb_q;
        det_clean_d  = det_clean_q;
        if (sync2_q == det_clean_q) begin
            deb_d = '0;
        end else if (tick) begin
            if (sat_inc(deb_q) == DEB_L) begin
                deb_d       = '0;
                det_clean_d = sync2_q;
            end else begin
                deb_d = sat_inc(deb_q);
            end
        end
    end

    assign rise = det_clean_q & ~clean_prev_q;

    always_comb begin
        veh_d = veh_q;
        if (clr_count) begin
            veh_d = '0;
        end else if (rise && veh_q != 8'hFF) begin
            veh_d = veh_q + 8'd1;
        end
    end

    // max_t runs across REQ/EXT hand-offs; min_t is only reset from IDLE
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        ext_d   = ext_q;
        cool_d  = '0;
        unique case (state_q)
            IDLE: begin
                min_d = '0;
                max_d = '0;
                if (det_clean_q) state_d = REQ;
            end
            REQ: begin
                ext_d = '0;
                if (tick) begin
                    min_d = sat_inc(min_q);
                    max_d = sat_inc(max_q);
                    if (max_d == MAX_L) begin
                        state_d = COOL;
                    end else if (!det_clean_q && min_d >= MIN_L) begin
                        state_d = (EXT_L == 8'd0) ? IDLE : EXT;
                    end
                end
            end
            EXT: begin
                if (tick) begin
                    ext_d = sat_inc(ext_q);
                    max_d = sat_inc(max_q);
                end
                if (tick && max_d == MAX_L) begin
                    state_d = COOL;
                end else if (det_clean_q) begin
                    state_d = REQ;
                end else if (tick && ext_d == EXT_L) begin
                    state_d = IDLE;
                end
            end
            COOL: begin
                cool_d = cool_q;
                if (tick) begin
                    cool_d = sat_inc(cool_q);
                    if (cool_d == COOL_L) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_req_d    = (state_d == REQ) || (state_d == EXT);
        cooldown_d = (state_d == COOL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            det_clean_q  <= 1'b0;
            clean_prev_q <= 1'b0;
            deb_q        <= '0;
            veh_q        <= '0;
            state_q      <= IDLE;
            min_q        <= '0;
            max_q        <= '0;
            ext_q        <= '0;
            cool_q       <= '0;
            s_req_q      <= 1'b0;
            cooldown_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            det_clean_q  <= det_clean_d;
            clean_prev_q <= clean_prev_d;
            deb_q        <= deb_d;
            veh_q        <= veh_d;
            state_q      <= state_d;
            min_q        <= min_d;
            max_q        <= max_d;
            ext_q        <= ext_d;
            cool_q       <= cool_d;
            s_req_q      <= s_req_d;
            cooldown_q   <= cooldown_d;
        end
    end

    assign s_req     = s_req_q;
    assign det_clean = det_clean_q;
    assign veh_count = veh_q;
    assign cooldown  = cooldown_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Randomised and directed bench for farm_sensor_conditioner, two
// instances (default gap extension and a longer one) against a model.
module tb_farm_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int MIN   = 8;
    localparam int MAX   = 60;
    localparam int COOL  = 20;
    localparam int EXT_A = 3;
    localparam int EXT_G = 6;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_EXT  = 2;
    localparam int P_COOL = 3;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       det_raw;
    logic       clr_count;
    logic       s_req, det_clean, cooldown;
    logic [7:0] veh_count;
    logic       s_req_g, det_clean_g, cooldown_g;
    logic [7:0] veh_count_g;

    int errors;
    int checks;

    farm_sensor_conditioner u_dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .det_raw   (det_raw),
        .clr_count (clr_count),
        .s_req     (s_req),
        .det_clean (det_clean),
        .veh_count (veh_count),
        .cooldown  (cooldown)
    );

    farm_sensor_conditioner #(.EXT_TICKS(EXT_G)) u_gap (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .det_raw   (det_raw),
        .clr_count (clr_count),
        .s_req     (s_req_g),
        .det_clean (det_clean_g),
        .veh_count (veh_count_g),
        .cooldown  (cooldown_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request shaper kept as countdown budgets rather than up-counters
    typedef struct packed {
        int s1;
        int s2;
        int clean;
        int prev;
        int deb;
        int cnt;
        int phase;
        int held;
        int budget;
        int grace;
        int rest;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mstep(input mdl_t m, input int ext_n,
                                   input bit t, input bit raw,
                                   input bit clr);
        mdl_t n;
        n = m;
        n.s1 = raw ? 1 : 0;
        n.s2 = m.s1;
        if (m.s2 == m.clean) begin
            n.deb = 0;
        end else if (t) begin
            n.deb = m.deb + 1;
            if (n.deb == DEB) begin
                n.deb = 0;
                n.clean = m.s2;
            end
        end
        n.prev = m.clean;
        if (clr) n.cnt = 0;
        else if (m.clean == 1 && m.prev == 0)
            n.cnt = (m.cnt == 255) ? 255 : m.cnt + 1;
        case (m.phase)
            P_IDLE: if (m.clean == 1) begin
                n.phase  = P_REQ;
                n.held   = 0;
                n.budget = MAX;
            end
            P_REQ: if (t) begin
                n.held   = m.held + 1;
                n.budget = m.budget - 1;
                if (n.budget == 0) begin
                    n.phase = P_COOL;
                    n.rest  = COOL;
                end else if (m.clean == 0 && n.held >= MIN) begin
                    if (ext_n == 0) begin
                        n.phase = P_IDLE;
                    end else begin
                        n.phase = P_EXT;
                        n.grace = ext_n;
                    end
                end
            end
            P_EXT: begin
                if (t) begin
                    n.budget = m.budget - 1;
                    n.grace  = m.grace - 1;
                end
                if (t && n.budget == 0) begin
                    n.phase = P_COOL;
                    n.rest  = COOL;
                end else if (m.clean == 1) begin
                    n.phase = P_REQ;
                end else if (t && n.grace == 0) begin
                    n.phase = P_IDLE;
                end
            end
            P_COOL: if (t) begin
                n.rest = m.rest - 1;
                if (n.rest == 0) n.phase = P_IDLE;
            end
            default: n.phase = P_IDLE;
        endcase
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        int busy0, busy1;
        busy0 = (m0.phase == P_REQ || m0.phase == P_EXT) ? 1 : 0;
        busy1 = (m1.phase == P_REQ || m1.phase == P_EXT) ? 1 : 0;
        chk("s_req",     32'(s_req),       busy0);
        chk("det_clean", 32'(det_clean),   m0.clean);
        chk("veh_count", 32'(veh_count),   m0.cnt);
        chk("cooldown",  32'(cooldown),    (m0.phase == P_COOL) ? 1 : 0);
        chk("s_req_g",   32'(s_req_g),     busy1);
        chk("clean_g",   32'(det_clean_g), m1.clean);
        chk("veh_g",     32'(veh_count_g), m1.cnt);
        chk("cool_g",    32'(cooldown_g),  (m1.phase == P_COOL) ? 1 : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            m0 = '0;
            m1 = '0;
        end else begin
            m0 = mstep(m0, EXT_A, tick, det_raw, clr_count);
            m1 = mstep(m1, EXT_G, tick, det_raw, clr_count);
        end
        #1;
        chk_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int hi_a, hi_g, lows, cnt, hold;
        bit hit;
        errors = 0;
        checks = 0;
        m0 = '0;
        m1 = '0;
        rst = 1'b1;
        tick = 1'b1;
        det_raw = 1'b1;
        clr_count = 1'b0;
        #2 rst = 1'b0;

        run(5);
        rst = 1'b1;
        det_raw = 1'b0;
        run(10);

        det_raw = 1'b1;
        run(3);
        det_raw = 1'b0;
        hi_a = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            hi_a += int'(det_clean) + int'(s_req);
        end
        chk("glitch_hi", 32'(hi_a), 0);
        chk("glitch_veh", 32'(veh_count), 0);

        hi_a = 0;
        hi_g = 0;
        det_raw = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 10) det_raw = 1'b0;
            cyc();
            hi_a += int'(s_req);
            hi_g += int'(s_req_g);
        end
        chk("short_len", 32'(hi_a), 13);
        chk("short_len_g", 32'(hi_g), 16);
        chk("short_veh", 32'(veh_count), 1);

        clr_count = 1'b1;
        cyc();
        clr_count = 1'b0;
        lows = 0;
        det_raw = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i == 12) det_raw = 1'b0;
            if (i == 16) det_raw = 1'b1;
            if (i == 28) det_raw = 1'b0;
            cyc();
            if (i >= 8 && i <= 30 && s_req_g !== 1'b1) lows++;
        end
        chk("gap_lows_g", 32'(lows), 0);
        chk("gap_veh", 32'(veh_count), 2);
        chk("gap_veh_g", 32'(veh_count_g), 2);

        det_raw = 1'b1;
        cnt = 0;
        while (s_req !== 1'b1 && cnt < 20) begin
            cyc();
            cnt++;
        end
        chk("starve_rise", 32'(s_req), 1);
        hi_a = 0;
        while (s_req === 1'b1 && hi_a < 200) begin
            hi_a++;
            cyc();
        end
        chk("starve_len", 32'(hi_a), MAX);
        cnt = 0;
        while (cooldown === 1'b1 && cnt < 200) begin
            cnt++;
            cyc();
        end
        chk("cool_len", 32'(cnt), COOL);
        hold = 0;
        while (s_req !== 1'b1 && hold < 5) begin
            cyc();
            hold++;
        end
        chk("starve_back", 32'(s_req), 1);
        run(10);

        #2 rst = 1'b0;
        #1;
        chk("arst_sreq", 32'(s_req), 0);
        chk("arst_sreq_g", 32'(s_req_g), 0);
        chk("arst_clean", 32'(det_clean), 0);
        chk("arst_veh", 32'(veh_count), 0);
        m0 = '0;
        m1 = '0;
        run(3);
        rst = 1'b1;
        det_raw = 1'b0;
        run(40);

        for (int i = 0; i < 40; i++) begin
            det_raw = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 14);
            for (int j = 0; j < hold; j++) begin
                tick = ($urandom_range(0, 3) != 0);
                clr_count = ($urandom_range(0, 31) == 0);
                cyc();
            end
        end
        tick = 1'b1;
        clr_count = 1'b0;

        for (int i = 0; i < 300; i++) begin
            det_raw = 1'b1;
            run(5);
            det_raw = 1'b0;
            run(5);
        end
        run(10);
        chk("veh_sat", 32'(veh_count), 255);
        chk("veh_sat_g", 32'(veh_count_g), 255);

        det_raw = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            clr_count = (m0.clean == 1 && m0.prev == 0);
            hit = clr_count;
            cyc();
        end
        clr_count = 1'b0;
        chk("clr_hit", 32'(hit), 1);
        chk("clr_rise", 32'(veh_count), 0);
        det_raw = 1'b0;
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
